// File: rtl/esm_pkg.sv
// Shared ESM definitions: default window geometry, index-width helper and the
// completion record exchanged with the issue-side shuffler.
package esm_pkg;

  localparam int unsigned BS_DEF = 16;
  localparam int unsigned DW_DEF = 32;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDX_W = idx_w(BS_DEF);

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [DW_DEF-1:0] data;
  } esm_cmp_t;

endpackage

// File: rtl/esm_retire_reorder_if.sv
// Allocation, completion, retire and flush signals of one ESM reorder window.
interface esm_retire_reorder_if
  import esm_pkg::*;
#(
  parameter int unsigned BS = 16,
  parameter int unsigned DW = 32
);
  localparam int unsigned IW = idx_w(BS);
  localparam int unsigned CW = IW + 1;

  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic          cmp_valid;
  logic [IW-1:0] cmp_index;
  logic [DW-1:0] cmp_data;
  logic          ret_valid;
  logic          ret_ready;
  logic [IW-1:0] ret_index;
  logic [DW-1:0] ret_data;
  logic [CW-1:0] occupancy;
  logic          cmp_err;
  logic          flush;

  modport master (
    output alloc_valid, cmp_valid, cmp_index, cmp_data, ret_ready, flush,
    input  alloc_ready, alloc_index, ret_valid, ret_index, ret_data,
           occupancy, cmp_err
  );

  modport slave (
    input  alloc_valid, cmp_valid, cmp_index, cmp_data, ret_ready, flush,
    output alloc_ready, alloc_index, ret_valid, ret_index, ret_data,
           occupancy, cmp_err
  );

endinterface

// File: rtl/esm_slot_store.sv
// Payload array for the reorder window: one write port, one async read port.
module esm_slot_store
  import esm_pkg::*;
#(
  parameter int unsigned bs = 16,
  parameter int unsigned dw = 32
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [idx_w(bs)-1:0] waddr_i,
  input  logic [dw-1:0]        wdata_i,
  input  logic [idx_w(bs)-1:0] raddr_i,
  output logic [dw-1:0]        rdata_o
);

  logic [dw-1:0] mem_q [bs];

  // Payloads are qualified by the done bitmap, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/esm_retire_reorder.sv
// Buffers out-of-order completions and releases them in allocation order.
module esm_retire_reorder
  import esm_pkg::*;
#(
  parameter int unsigned bs = 16,
  parameter int unsigned dw = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  esm_retire_reorder_if.slave  bus
);

  localparam int unsigned IW = idx_w(bs);
  localparam int unsigned CW = IW + 1;

  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [bs-1:0] pending_q, pending_d;
  logic [bs-1:0] done_q, done_d;
  logic          cmp_err_q, cmp_err_d;

  logic alloc_fire;
  logic ret_fire;
  logic ret_valid_c;
  logic cmp_ok;
  logic cmp_bad;
  logic store_we;

  assign ret_valid_c = pending_q[head_q] & done_q[head_q];
  assign alloc_fire  = bus.alloc_valid & (count_q < CW'(bs));
  assign ret_fire    = ret_valid_c & bus.ret_ready;
  assign cmp_ok      = bus.cmp_valid & pending_q[bus.cmp_index] & ~done_q[bus.cmp_index];
  assign cmp_bad     = bus.cmp_valid & ~cmp_ok;
  assign store_we    = cmp_ok & ~bus.flush;

  // Retire clears before alloc sets so a shared slot ends up pending, not done.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pending_d = pending_q;
    done_d    = done_q;
    cmp_err_d = cmp_err_q;

    if (bus.flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      pending_d = '0;
      done_d    = '0;
    end else begin
      if (ret_fire) begin
        pending_d[head_q] = 1'b0;
        done_d[head_q]    = 1'b0;
        head_d            = head_q + IW'(1);
      end
      if (cmp_ok) done_d[bus.cmp_index] = 1'b1;
      if (alloc_fire) begin
        pending_d[tail_q] = 1'b1;
        done_d[tail_q]    = 1'b0;
        tail_d            = tail_q + IW'(1);
      end
      case ({alloc_fire, ret_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (cmp_bad) cmp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
      cmp_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      cmp_err_q <= cmp_err_d;
    end
  end

  esm_slot_store #(
    .bs (bs),
    .dw (dw)
  ) u_store (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (bus.cmp_index),
    .wdata_i (bus.cmp_data),
    .raddr_i (head_q),
    .rdata_o (bus.ret_data)
  );

  assign bus.alloc_ready = (count_q < CW'(bs));
  assign bus.alloc_index = tail_q;
  assign bus.ret_valid   = ret_valid_c;
  assign bus.ret_index   = head_q;
  assign bus.occupancy   = count_q;
  assign bus.cmp_err     = cmp_err_q;

endmodule

// File: tb/tb_esm_retire_reorder.sv
// Directed bench for esm_retire_reorder: ordering, full window, wrap, errors, flush, reset.
module tb_esm_retire_reorder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  esm_retire_reorder_if #(.BS(16), .DW(32)) bus ();

  esm_retire_reorder #(.bs(16), .dw(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passed = 0;
  int total  = 0;
  int ord [4] = '{2, 0, 3, 1};
  logic [31:0] dat [4] = '{32'hA2, 32'hA0, 32'hA3, 32'hA1};
  int perm [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.cmp_valid   = 1'b0;
    bus.cmp_index   = '0;
    bus.cmp_data    = '0;
    bus.ret_ready   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic complete(input int idx, input logic [31:0] d);
    bus.cmp_valid = 1'b1;
    bus.cmp_index = 4'(idx);
    bus.cmp_data  = d;
    tick();
    bus.cmp_valid = 1'b0;
  endtask

  initial begin
    int got;
    int guard;
    int s;
    int j;
    int tmp;
    logic rr;

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_index", bus.alloc_index, 0);
    chk("rst_ret_valid", bus.ret_valid, 0);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_cmp_err", bus.cmp_err, 0);

    // Shuffled completion, in-order retire
    for (int i = 0; i < 4; i++) begin
      bus.alloc_valid = 1'b1;
      chk("ord_alloc_index", bus.alloc_index, 64'(i));
      tick();
    end
    bus.alloc_valid = 1'b0;
    chk("ord_occupancy", bus.occupancy, 4);
    for (int i = 0; i < 4; i++) begin
      complete(ord[i], dat[i]);
      chk("ord_ret_valid_rise", bus.ret_valid, 64'(i >= 1));
    end
    bus.ret_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ord_ret_valid", bus.ret_valid, 1);
      chk("ord_ret_index", bus.ret_index, 64'(i));
      chk("ord_ret_data", bus.ret_data, 64'(32'hA0 + i));
      tick();
    end
    bus.ret_ready = 1'b0;
    chk("ord_empty_ret_valid", bus.ret_valid, 0);
    chk("ord_empty_occ", bus.occupancy, 0);

    // Full window
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.alloc_valid = 1'b1;
      chk("full_alloc_index", bus.alloc_index, 64'(i));
      tick();
    end
    chk("full_alloc_ready", bus.alloc_ready, 0);
    chk("full_occ", bus.occupancy, 16);
    tick();
    chk("full_17th_occ", bus.occupancy, 16);
    chk("full_17th_tail", bus.alloc_index, 0);
    complete(0, 32'hB0);
    chk("full_ret_valid", bus.ret_valid, 1);
    chk("full_ret_data", bus.ret_data, 32'hB0);
    chk("full_still_full", bus.alloc_ready, 0);
    bus.ret_ready = 1'b1;
    tick();
    bus.ret_ready = 1'b0;
    chk("full_after_ret_occ", bus.occupancy, 15);
    chk("full_after_ret_ready", bus.alloc_ready, 1);
    chk("full_regrant_index", bus.alloc_index, 0);
    chk("full_after_ret_valid", bus.ret_valid, 0);
    tick();
    bus.alloc_valid = 1'b0;
    chk("full_refill_occ", bus.occupancy, 16);
    chk("full_refill_ready", bus.alloc_ready, 0);
    chk("full_refill_tail", bus.alloc_index, 1);
    chk("full_no_err", bus.cmp_err, 0);

    // Wrap-around: 5 batches of 8, shuffled completions, random ret_ready
    do_reset();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) begin
        bus.alloc_valid = 1'b1;
        chk("wrap_alloc_index", bus.alloc_index, 64'((b * 8 + i) % 16));
        tick();
      end
      bus.alloc_valid = 1'b0;
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      for (int i = 0; i < 8; i++) begin
        s = b * 8 + perm[i];
        complete(s % 16, 32'hC000_0000 + 32'(s));
      end
      got = 0;
      guard = 0;
      while (got < 8 && guard < 200) begin
        rr = 1'($urandom_range(0, 1));
        bus.ret_ready = rr;
        s = b * 8 + got;
        chk("wrap_ret_valid", bus.ret_valid, 1);
        chk("wrap_ret_index", bus.ret_index, 64'(s % 16));
        chk("wrap_ret_data", bus.ret_data, 64'(32'hC000_0000 + 32'(s)));
        if (rr) got++;
        guard++;
        tick();
      end
      bus.ret_ready = 1'b0;
      chk("wrap_batch_done", 64'(got), 8);
      chk("wrap_batch_occ", bus.occupancy, 0);
    end

    // Illegal completions
    do_reset();
    complete(5, 32'hDEAD);
    chk("err_unalloc", bus.cmp_err, 1);
    bus.alloc_valid = 1'b1;
    tick();
    tick();
    bus.alloc_valid = 1'b0;
    complete(1, 32'hD1);
    complete(1, 32'hD2);
    complete(0, 32'hD0);
    chk("err_sticky", bus.cmp_err, 1);
    bus.ret_ready = 1'b1;
    chk("err_ret0_data", bus.ret_data, 32'hD0);
    tick();
    chk("err_ret1_index", bus.ret_index, 1);
    chk("err_ret1_data", bus.ret_data, 32'hD1);
    tick();
    bus.ret_ready = 1'b0;
    chk("err_drained", bus.occupancy, 0);

    // Flush with head completed; alloc asserted to show flush wins
    for (int i = 0; i < 6; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    bus.alloc_valid = 1'b0;
    complete(2, 32'hE2);
    complete(4, 32'hE4);
    complete(6, 32'hE6);
    chk("flush_pre_ret_valid", bus.ret_valid, 1);
    chk("flush_pre_occ", bus.occupancy, 6);
    bus.flush = 1'b1;
    bus.alloc_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    chk("flush_occ", bus.occupancy, 0);
    chk("flush_ret_valid", bus.ret_valid, 0);
    chk("flush_alloc_index", bus.alloc_index, 0);
    chk("flush_alloc_ready", bus.alloc_ready, 1);
    chk("flush_cmp_err_kept", bus.cmp_err, 1);

    // Reset mid-operation with flush also asserted
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    bus.alloc_valid = 1'b0;
    complete(0, 32'hF0);
    chk("midrst_pre_occ", bus.occupancy, 8);
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    chk("midrst_alloc_ready", bus.alloc_ready, 1);
    chk("midrst_alloc_index", bus.alloc_index, 0);
    chk("midrst_ret_valid", bus.ret_valid, 0);
    chk("midrst_occ", bus.occupancy, 0);
    chk("midrst_cmp_err", bus.cmp_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
